// File: rtl/clause_eval_scheduler_pkg.sv
// Shared types for the WalkSAT clause scheduler: clause word layout, FSM states, LFSR taps.
package wsat_pkg;
    localparam int CL_VAR_AW = 11;
    localparam int LFSR_W    = 20;
    // Taps 20 and 17 of a 20-bit Fibonacci LFSR, as bit positions 19 and 16.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 20'h90000;

    typedef struct packed {
        logic                 neg1;
        logic [CL_VAR_AW-1:0] var1;
        logic                 neg2;
        logic [CL_VAR_AW-1:0] var2;
    } clause_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_DECIDE,
        S_FLIP,
        S_DONE
    } sched_state_e;
endpackage

// File: rtl/clause_eval_scheduler_lfsr.sv
// Free-running Fibonacci LFSR; shifts toward the MSB and feeds the tap parity into bit 0.
module wsat_lfsr #(
    parameter int               WIDTH = 20,
    parameter logic [WIDTH-1:0] SEED  = 20'h00001,
    parameter logic [WIDTH-1:0] TAPS  = 20'h90000,
    parameter int               OUT_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic [OUT_W-1:0] rnd_o
);
    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;

    always_comb lfsr_d = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};

    always_ff @(posedge clk_i) begin
        if (rst_i) lfsr_q <= SEED;
        else       lfsr_q <= lfsr_d;
    end

    // Only the low bits are consumed by the scheduler.
    assign rnd_o = lfsr_q[OUT_W-1:0];
endmodule

// File: rtl/clause_eval_scheduler.sv
// WalkSAT try sequencer: scans all 2-literal clauses through the evaluator, picks an unsat
// clause and literal at random, and commands the flip until sat or out of flip budget.
module clause_eval_scheduler
    import wsat_pkg::*;
#(
    parameter int                VAR_AW    = 11,
    parameter int                CLAUSE_AW = 12,
    parameter int                FLIP_W    = 20,
    parameter logic [FLIP_W-1:0] MAX_FLIPS = 20'd1000,
    parameter logic [19:0]       LFSR_SEED = 20'h00001
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CLAUSE_AW-1:0]  num_clauses,
    output logic                  busy,
    output logic                  done,
    output logic                  sat,
    output logic [FLIP_W-1:0]     flip_count,
    output logic                  cm_read,
    output logic [CLAUSE_AW-1:0]  cm_address,
    input  logic [2*VAR_AW+1:0]   cm_data,
    output logic                  read1,
    output logic                  read2,
    output logic                  neg_bit1,
    output logic                  neg_bit2,
    output logic [VAR_AW-1:0]     var_address1,
    output logic [VAR_AW-1:0]     var_address2,
    input  logic                  eval_valid,
    input  logic                  eval_sat,
    output logic                  write,
    output logic [VAR_AW-1:0]     flip_var_address,
    input  logic                  flip_ack
);
    sched_state_e          state_q, state_d;
    logic [CLAUSE_AW-1:0]  idx_q, idx_d;
    logic [CLAUSE_AW-1:0]  num_q, num_d;
    logic [CLAUSE_AW:0]    unsat_q, unsat_d;
    clause_t               clause_q, clause_d;
    clause_t               cand_q, cand_d;
    logic [VAR_AW-1:0]     flip_addr_q, flip_addr_d;
    logic [FLIP_W-1:0]     flip_cnt_q, flip_cnt_d;
    logic                  sat_q, sat_d;
    logic [1:0]            rnd;
    logic                  last_clause;

    wsat_lfsr #(
        .WIDTH (LFSR_W),
        .SEED  (LFSR_SEED),
        .TAPS  (LFSR_TAPS),
        .OUT_W (2)
    ) u_lfsr (
        .clk_i (clk),
        .rst_i (rst),
        .rnd_o (rnd)
    );

    assign last_clause = (idx_q == num_q - CLAUSE_AW'(1));

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        num_d       = num_q;
        unsat_d     = unsat_q;
        clause_d    = clause_q;
        cand_d      = cand_q;
        flip_addr_d = flip_addr_q;
        flip_cnt_d  = flip_cnt_q;
        sat_d       = sat_q;
        busy        = 1'b1;
        done        = 1'b0;
        cm_read     = 1'b0;
        cm_address  = '0;
        read1       = 1'b0;
        read2       = 1'b0;
        write       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    sat_d      = 1'b0;
                    flip_cnt_d = '0;
                    idx_d      = '0;
                    unsat_d    = '0;
                    cand_d     = '0;
                    num_d      = num_clauses;
                    if (num_clauses == '0) begin
                        sat_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                cm_read    = 1'b1;
                cm_address = idx_q;
                state_d    = S_LOAD;
            end
            S_LOAD: begin
                clause_d = clause_t'(cm_data);
                state_d  = S_ISSUE;
            end
            S_ISSUE: begin
                read1   = 1'b1;
                read2   = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (eval_valid) begin
                    // Reservoir-style pick: first unsat clause always, later ones on a coin flip.
                    if (!eval_sat) begin
                        unsat_d = unsat_q + 1'b1;
                        if (unsat_q == '0 || rnd[0]) cand_d = clause_q;
                    end
                    if (last_clause) begin
                        state_d = S_DECIDE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DECIDE: begin
                if (unsat_q == '0) begin
                    sat_d   = 1'b1;
                    state_d = S_DONE;
                end else if (flip_cnt_q == MAX_FLIPS) begin
                    sat_d   = 1'b0;
                    state_d = S_DONE;
                end else begin
                    flip_addr_d = rnd[1] ? cand_q.var2 : cand_q.var1;
                    state_d     = S_FLIP;
                end
            end
            S_FLIP: begin
                write = 1'b1;
                if (flip_ack) begin
                    flip_cnt_d = flip_cnt_q + 1'b1;
                    idx_d      = '0;
                    unsat_d    = '0;
                    cand_d     = '0;
                    state_d    = S_FETCH;
                end
            end
            S_DONE: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            num_q       <= '0;
            unsat_q     <= '0;
            clause_q    <= '0;
            cand_q      <= '0;
            flip_addr_q <= '0;
            flip_cnt_q  <= '0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            num_q       <= num_d;
            unsat_q     <= unsat_d;
            clause_q    <= clause_d;
            cand_q      <= cand_d;
            flip_addr_q <= flip_addr_d;
            flip_cnt_q  <= flip_cnt_d;
            sat_q       <= sat_d;
        end
    end

    assign sat              = sat_q;
    assign flip_count       = flip_cnt_q;
    assign flip_var_address = flip_addr_q;
    assign neg_bit1         = clause_q.neg1;
    assign neg_bit2         = clause_q.neg2;
    assign var_address1     = clause_q.var1;
    assign var_address2     = clause_q.var2;
endmodule

// File: tb/tb_clause_eval_scheduler.sv
// Directed bench: memory/evaluator responders plus a scan-level WalkSAT model checked every cycle.
module tb_clause_eval_scheduler;
    import wsat_pkg::*;

    localparam int                VAR_AW    = 11;
    localparam int                CLAUSE_AW = 12;
    localparam int                FLIP_W    = 20;
    localparam logic [FLIP_W-1:0] MAXF      = 20'd3;
    localparam logic [19:0]       SEED      = 20'h00001;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic [CLAUSE_AW-1:0] num_clauses = '0;
    logic                 busy, done, sat, cm_read, read1, read2, neg_bit1, neg_bit2, write;
    logic [FLIP_W-1:0]    flip_count;
    logic [CLAUSE_AW-1:0] cm_address;
    logic [2*VAR_AW+1:0]  cm_data = '0;
    logic [VAR_AW-1:0]    var_address1, var_address2, flip_var_address;
    logic                 eval_valid = 1'b0, eval_sat = 1'b0, flip_ack = 1'b0;

    always #5 clk = ~clk;

    clause_eval_scheduler #(
        .VAR_AW(VAR_AW), .CLAUSE_AW(CLAUSE_AW), .FLIP_W(FLIP_W),
        .MAX_FLIPS(MAXF), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_clauses(num_clauses),
        .busy(busy), .done(done), .sat(sat), .flip_count(flip_count),
        .cm_read(cm_read), .cm_address(cm_address), .cm_data(cm_data),
        .read1(read1), .read2(read2), .neg_bit1(neg_bit1), .neg_bit2(neg_bit2),
        .var_address1(var_address1), .var_address2(var_address2),
        .eval_valid(eval_valid), .eval_sat(eval_sat),
        .write(write), .flip_var_address(flip_var_address), .flip_ack(flip_ack)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [19:0] lfsr_next(input logic [19:0] l);
        return {l[18:0], l[19] ^ l[16]};
    endfunction

    int          cyc = 0;
    logic [19:0] tb_l;
    always @(posedge clk) begin
        cyc  <= cyc + 1;
        tb_l <= rst ? SEED : lfsr_next(tb_l);
    end

    // Scan-level model and responder configuration
    clause_t     mem [4];
    logic [3:0]  unsat_mask = '0;
    bit          clear_on_flip = 0;
    bit          stray_en = 0;
    int          ev_dly = 1;
    int          ack_dly = 1;
    int          m_idx = 0, m_num = 0, m_cnt = 0, m_flips = 0;
    clause_t     m_cand = '0;
    int          cur = 0, ev_cnt = 0, wcnt = 0;
    bit          in_wait = 0, prev_write = 0;
    clause_t     wait_cl = '0;
    logic [10:0] w_exp = '0, last_fva = '0;
    logic [19:0] prev_l = '0;
    int          n_cmread = 0, n_write = 0, n_done = 0, done_cyc = 0, s_cyc = 0;

    always @(negedge clk) begin
        if (rst) begin
            eval_valid = 0; eval_sat = 0; flip_ack = 0;
            ev_cnt = 0; in_wait = 0; wcnt = 0; prev_write = 0;
        end else begin
            if (cm_read) begin
                n_cmread++;
                chk("cm_in_range", 32'(m_idx < m_num), 1);
                chk("cm_address", 32'(cm_address), m_idx);
                cur = m_idx;
                m_idx++;
                cm_data = mem[cur % 4];
            end
            eval_valid = 0;
            eval_sat   = 0;
            if (in_wait) begin
                chk("read_pulse", {read1, read2}, 0);
                chk("lit_stable", {neg_bit1, var_address1, neg_bit2, var_address2}, wait_cl);
                chk("busy_wait", busy, 1);
                ev_cnt--;
                if (ev_cnt == 0) begin
                    eval_valid = 1;
                    eval_sat   = !unsat_mask[cur % 4];
                    in_wait    = 0;
                    if (!eval_sat) begin
                        if (m_cnt == 0 || tb_l[0]) m_cand = mem[cur % 4];
                        m_cnt++;
                    end
                end
            end
            if (read1 || read2) begin
                chk("read_pair", {read1, read2}, 2'b11);
                wait_cl = mem[cur % 4];
                chk("lit_issue", {neg_bit1, var_address1, neg_bit2, var_address2}, wait_cl);
                in_wait = 1;
                ev_cnt  = ev_dly;
            end
            if (stray_en && cm_read) begin
                eval_valid = 1;
                eval_sat   = 0;
            end
            flip_ack = 0;
            if (write) begin
                if (!prev_write) begin
                    n_write++;
                    chk("write_needed", 32'((m_cnt != 0) && (m_flips < int'(MAXF))), 1);
                    w_exp = prev_l[1] ? m_cand.var2 : m_cand.var1;
                    chk("flip_addr", flip_var_address, w_exp);
                    last_fva = flip_var_address;
                    wcnt = 0;
                end else begin
                    chk("flip_stable", flip_var_address, w_exp);
                end
                wcnt++;
                if (wcnt == ack_dly) begin
                    flip_ack = 1;
                    wcnt     = 0;
                    m_flips++;
                    m_idx = 0;
                    m_cnt = 0;
                    if (clear_on_flip) unsat_mask = '0;
                end
            end
            prev_write = write;
            if (done) begin
                n_done++;
                done_cyc = cyc;
                chk("done_legal", 32'((m_cnt == 0) || (m_flips == int'(MAXF))), 1);
                chk("sat", sat, 32'(m_cnt == 0));
                chk("flip_count", flip_count, m_flips);
                chk("busy_in_done", busy, 0);
            end
            prev_l = tb_l;
        end
    end

    task automatic do_start(input int n);
        @(negedge clk);
        m_idx = 0; m_num = n; m_cnt = 0; m_flips = 0; m_cand = '0;
        num_clauses = CLAUSE_AW'(n);
        start = 1;
        s_cyc = cyc;
        @(negedge clk);
        start = 0;
        if (n > 0) chk("busy_after_start", busy, 1);
    endtask

    task automatic wait_done(input int budget, input int base_n);
        int k = 0;
        while (n_done == base_n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen", 32'(n_done > base_n), 1);
        @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {busy, done, sat, cm_read, read1, read2, neg_bit1, neg_bit2, write}, 0);
        chk({tag, "_fc"}, flip_count, 0);
        chk({tag, "_cma"}, cm_address, 0);
        chk({tag, "_var"}, {var_address1, var_address2}, 0);
        chk({tag, "_fva"}, flip_var_address, 0);
    endtask

    initial begin
        int base, rd0, wr0, k;
        logic [19:0] l;
        mem[0] = '{neg1: 1'b0, var1: 11'd5,   neg2: 1'b1, var2: 11'd9};
        mem[1] = '{neg1: 1'b1, var1: 11'd17,  neg2: 1'b0, var2: 11'd300};
        mem[2] = '{neg1: 1'b1, var1: 11'd2047, neg2: 1'b1, var2: 11'd1};
        mem[3] = '{neg1: 1'b0, var1: 11'd64,  neg2: 1'b0, var2: 11'd1024};

        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 0;

        l = SEED;
        repeat (17) l = lfsr_next(l);
        chk("lfsr_model", l, 20'h20001);

        // 1: reset held 3 cycles while waiting on the evaluator
        ev_dly = 50; unsat_mask = '0;
        base = n_done;
        do_start(2);
        k = 0;
        while (!in_wait && k < 20) begin @(negedge clk); k++; end
        chk("t1_reach_wait", in_wait, 1);
        repeat (2) @(negedge clk);
        rst = 1;
        repeat (3) @(negedge clk);
        chk_zero("t1_rst");
        rst = 0;
        repeat (5) @(negedge clk);
        chk("t1_no_done", n_done, base);
        chk("t1_idle", {busy, write, cm_read}, 0);
        ev_dly = 1;

        // 2: empty clause set
        base = n_done; rd0 = n_cmread;
        do_start(0);
        wait_done(10, base);
        chk("t2_done_cycle", 32'((done_cyc - s_cyc) <= 2), 1);
        chk("t2_no_cmread", n_cmread - rd0, 0);
        chk("t2_sat", sat, 1);
        chk("t2_fc", flip_count, 0);

        // 3: four clauses, all satisfied, 1-cycle evaluator
        base = n_done; rd0 = n_cmread;
        do_start(4);
        wait_done(100, base);
        chk("t3_done_cycle", done_cyc - s_cyc, 18);
        chk("t3_cmreads", n_cmread - rd0, 4);
        chk("t3_sat", sat, 1);
        chk("t3_fc", flip_count, 0);

        // 4: clause 1 unsat until the first flip
        unsat_mask = 4'b0010; clear_on_flip = 1;
        base = n_done; wr0 = n_write;
        do_start(2);
        wait_done(200, base);
        chk("t4_writes", n_write - wr0, 1);
        chk("t4_fva_in_clause", 32'(last_fva == 11'd17 || last_fva == 11'd300), 1);
        chk("t4_fc", flip_count, 1);
        chk("t4_sat", sat, 1);

        // 5: never satisfiable, flip budget of 3
        unsat_mask = 4'b0011; clear_on_flip = 0;
        base = n_done; wr0 = n_write;
        do_start(2);
        wait_done(400, base);
        chk("t5_writes", n_write - wr0, 3);
        chk("t5_fc", flip_count, 3);
        chk("t5_sat", sat, 0);

        // 6: slow evaluator and ack, stray eval_valid during fetch
        ev_dly = 5; ack_dly = 4; stray_en = 1;
        unsat_mask = 4'b0001; clear_on_flip = 1;
        base = n_done; wr0 = n_write; rd0 = n_cmread;
        do_start(2);
        wait_done(400, base);
        chk("t6_writes", n_write - wr0, 1);
        chk("t6_cmreads", n_cmread - rd0, 4);
        chk("t6_fc", flip_count, 1);
        chk("t6_sat", sat, 1);
        stray_en = 0; ev_dly = 1; ack_dly = 1;

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
